// File: rtl/next_line_prefetch_buffer.sv
// Line-read path between the L2 miss port and the pmem arbiter, with a one-line
// next-line prefetch buffer that answers sequential demand reads without pmem traffic.
module next_line_prefetch_buffer #(
  parameter bit PF_ENABLE = 1'b1,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cache_read,
  input  logic                 cache_write,
  input  logic [31:0]          cache_addr,
  input  logic [255:0]         cache_wdata,
  output logic                 cache_resp,
  output logic [255:0]         cache_rdata,
  output logic                 mem_read,
  output logic                 mem_write,
  output logic [31:0]          mem_addr,
  output logic [255:0]         mem_wdata,
  input  logic                 mem_resp,
  input  logic [255:0]         mem_rdata,
  output logic [CNT_WIDTH-1:0] hit_count,
  output logic [CNT_WIDTH-1:0] miss_count
);

  typedef enum logic [2:0] {S_IDLE, S_HIT, S_DEMAND, S_WRITE, S_PF} state_t;

  state_t                 state_reg, state_next;
  logic                   buf_valid_reg, buf_valid_next;
  logic [26:0]            buf_tag_reg, buf_tag_next;
  logic [255:0]           buf_data_reg, buf_data_next;
  logic [26:0]            pf_tag_reg, pf_tag_next;
  logic [CNT_WIDTH-1:0]   hit_count_reg, miss_count_reg;
  logic                   hit_inc, miss_inc;
  logic                   launch;
  logic [26:0]            launch_tag;
  logic [26:0]            req_tag;
  logic                   buf_hit;
  logic                   unused_addr_bits;

  assign req_tag          = cache_addr[31:5];
  assign buf_hit          = buf_valid_reg && (buf_tag_reg == req_tag);
  assign unused_addr_bits = ^cache_addr[4:0];
  assign hit_count        = hit_count_reg;
  assign miss_count       = miss_count_reg;

  always_comb begin
    state_next     = state_reg;
    buf_valid_next = buf_valid_reg;
    buf_tag_next   = buf_tag_reg;
    buf_data_next  = buf_data_reg;
    pf_tag_next    = pf_tag_reg;
    hit_inc        = 1'b0;
    miss_inc       = 1'b0;
    launch         = 1'b0;
    launch_tag     = '0;
    cache_resp     = 1'b0;
    cache_rdata    = '0;
    mem_read       = 1'b0;
    mem_write      = 1'b0;
    mem_addr       = '0;
    mem_wdata      = '0;

    case (state_reg)
      S_IDLE: begin
        if (cache_write) begin
          state_next = S_WRITE;
        end else if (cache_read) begin
          if (buf_hit) begin
            state_next = S_HIT;
          end else begin
            state_next = S_DEMAND;
            miss_inc   = 1'b1;
          end
        end
      end
      S_HIT: begin
        cache_resp  = 1'b1;
        cache_rdata = buf_data_reg;
        hit_inc     = 1'b1;
        launch      = 1'b1;
        launch_tag  = buf_tag_reg;
      end
      S_DEMAND: begin
        mem_read = 1'b1;
        mem_addr = {req_tag, 5'b0};
        if (mem_resp) begin
          cache_resp  = 1'b1;
          cache_rdata = mem_rdata;
          launch      = 1'b1;
          launch_tag  = req_tag;
        end
      end
      S_WRITE: begin
        mem_write = 1'b1;
        mem_addr  = {req_tag, 5'b0};
        mem_wdata = cache_wdata;
        if (mem_resp) begin
          cache_resp = 1'b1;
          state_next = S_IDLE;
          if (buf_tag_reg == req_tag) buf_valid_next = 1'b0;
        end
      end
      S_PF: begin
        mem_read = 1'b1;
        mem_addr = {pf_tag_reg, 5'b0};
        if (mem_resp) begin
          buf_data_next  = mem_rdata;
          buf_tag_next   = pf_tag_reg;
          buf_valid_next = 1'b1;
          state_next     = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase

    // After a served read, fetch the following line unless it would wrap past the top.
    if (launch) begin
      if (PF_ENABLE && !(&launch_tag)) begin
        state_next     = S_PF;
        pf_tag_next    = launch_tag + 27'd1;
        buf_valid_next = 1'b0;
      end else begin
        state_next = S_IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= S_IDLE;
      buf_valid_reg  <= 1'b0;
      buf_tag_reg    <= '0;
      buf_data_reg   <= '0;
      pf_tag_reg     <= '0;
      hit_count_reg  <= '0;
      miss_count_reg <= '0;
    end else begin
      state_reg     <= state_next;
      buf_valid_reg <= buf_valid_next;
      buf_tag_reg   <= buf_tag_next;
      buf_data_reg  <= buf_data_next;
      pf_tag_reg    <= pf_tag_next;
      // Statistics saturate rather than wrap.
      if (hit_inc && !(&hit_count_reg))   hit_count_reg  <= hit_count_reg + CNT_WIDTH'(1);
      if (miss_inc && !(&miss_count_reg)) miss_count_reg <= miss_count_reg + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_next_line_prefetch_buffer.sv
// Scoreboard bench: instance 0 has prefetch enabled, instance 1 has prefetch off and
// 2-bit counters so saturation is reachable.
module tb_next_line_prefetch_buffer;

  typedef struct {
    logic         wr;
    logic [31:0]  addr;
    logic [255:0] data;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         cache_read  [2];
  logic         cache_write [2];
  logic [31:0]  cache_addr  [2];
  logic [255:0] cache_wdata [2];
  logic         cache_resp  [2];
  logic [255:0] cache_rdata [2];
  logic         mem_read    [2];
  logic         mem_write   [2];
  logic [31:0]  mem_addr    [2];
  logic [255:0] mem_wdata   [2];
  logic         mem_resp    [2];
  logic [255:0] mem_rdata   [2];
  logic [15:0]  hit0, miss0;
  logic [1:0]   hit1, miss1;

  exp_t q_mem0[$];
  exp_t q_mem1[$];
  exp_t q_cache0[$];
  exp_t q_cache1[$];
  int   checks = 0;
  int   passes = 0;
  int   lat;

  always #5 clk = ~clk;

  next_line_prefetch_buffer #(.PF_ENABLE(1'b1), .CNT_WIDTH(16)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .cache_read(cache_read[0]), .cache_write(cache_write[0]), .cache_addr(cache_addr[0]),
    .cache_wdata(cache_wdata[0]), .cache_resp(cache_resp[0]), .cache_rdata(cache_rdata[0]),
    .mem_read(mem_read[0]), .mem_write(mem_write[0]), .mem_addr(mem_addr[0]),
    .mem_wdata(mem_wdata[0]), .mem_resp(mem_resp[0]), .mem_rdata(mem_rdata[0]),
    .hit_count(hit0), .miss_count(miss0)
  );

  next_line_prefetch_buffer #(.PF_ENABLE(1'b0), .CNT_WIDTH(2)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .cache_read(cache_read[1]), .cache_write(cache_write[1]), .cache_addr(cache_addr[1]),
    .cache_wdata(cache_wdata[1]), .cache_resp(cache_resp[1]), .cache_rdata(cache_rdata[1]),
    .mem_read(mem_read[1]), .mem_write(mem_write[1]), .mem_addr(mem_addr[1]),
    .mem_wdata(mem_wdata[1]), .mem_resp(mem_resp[1]), .mem_rdata(mem_rdata[1]),
    .hit_count(hit1), .miss_count(miss1)
  );

  function automatic logic [255:0] line_data(logic [31:0] a);
    return {8{a ^ 32'hC0DE_0000}};
  endfunction

  task automatic chk(string name, logic [255:0] act, logic [255:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h want %h", name, act, exp);
  endtask

  task automatic push_mem(int i, logic wr, logic [31:0] a, logic [255:0] d);
    exp_t e;
    e.wr = wr; e.addr = a; e.data = d;
    if (i == 0) q_mem0.push_back(e);
    else q_mem1.push_back(e);
  endtask

  task automatic push_cache(int i, logic wr, logic [31:0] a, logic [255:0] d);
    exp_t e;
    e.wr = wr; e.addr = a; e.data = d;
    if (i == 0) q_cache0.push_back(e);
    else q_cache1.push_back(e);
  endtask

  // Issues one held request and waits (bounded) for its cache_resp; lat = edges to response.
  task automatic do_req(input int i, input logic wr, input logic [31:0] a,
                        input logic [255:0] d, output int l);
    bit done = 0;
    push_cache(i, wr, a, d);
    cache_addr[i] = a;
    cache_wdata[i] = wr ? d : '0;
    if (wr) cache_write[i] = 1'b1;
    else cache_read[i] = 1'b1;
    l = 0;
    while (!done && l < 200) begin
      @(negedge clk);
      if (cache_resp[i]) done = 1;
      else l++;
    end
    if (!done) begin
      checks++;
      $display("FAIL timeout[%0d]: no cache_resp for addr %h within 200 cycles", i, a);
    end
    @(posedge clk); #1;
    cache_read[i] = 1'b0;
    cache_write[i] = 1'b0;
  endtask

  task automatic idle(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Arbiter model: answers any held request after three cycles.
  initial begin
    int busy[2];
    for (int i = 0; i < 2; i++) begin
      mem_resp[i] = 1'b0; mem_rdata[i] = '0; busy[i] = 0;
    end
    forever begin
      @(posedge clk); #1;
      for (int i = 0; i < 2; i++) begin
        mem_resp[i] = 1'b0;
        if (!rst_n || !(mem_read[i] || mem_write[i])) begin
          busy[i] = 0;
        end else begin
          busy[i]++;
          if (busy[i] == 3) begin
            mem_resp[i]  = 1'b1;
            mem_rdata[i] = mem_read[i] ? line_data(mem_addr[i]) : '0;
            busy[i]      = 0;
          end
        end
      end
    end
  end

  // Monitor: compares every completed mem transfer and cache response against the queues.
  always @(negedge clk) begin
    exp_t e;
    bit   have;
    if (rst_n) begin
      for (int i = 0; i < 2; i++) begin
        if (mem_read[i] && mem_write[i]) begin
          checks++;
          $display("FAIL mem_exclusive[%0d]: got read=1 write=1 want at most one", i);
        end
        if (mem_resp[i]) begin
          have = (i == 0) ? (q_mem0.size() != 0) : (q_mem1.size() != 0);
          if (!have) begin
            checks++;
            $display("FAIL mem_unexpected[%0d]: got addr %h want no transfer", i, mem_addr[i]);
          end else begin
            if (i == 0) e = q_mem0.pop_front();
            else e = q_mem1.pop_front();
            chk($sformatf("mem_op[%0d]", i), 256'(mem_write[i]), 256'(e.wr));
            chk($sformatf("mem_addr[%0d]", i), 256'(mem_addr[i]), 256'(e.addr));
            if (e.wr) chk($sformatf("mem_wdata[%0d]", i), mem_wdata[i], e.data);
          end
        end
        if (cache_resp[i]) begin
          have = (i == 0) ? (q_cache0.size() != 0) : (q_cache1.size() != 0);
          if (!have) begin
            checks++;
            $display("FAIL resp_unexpected[%0d]: got cache_resp=1 want 0", i);
          end else begin
            if (i == 0) e = q_cache0.pop_front();
            else e = q_cache1.pop_front();
            if (!e.wr) chk($sformatf("rdata[%0d] %h", i, e.addr), cache_rdata[i], e.data);
          end
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      cache_read[i] = 1'b0; cache_write[i] = 1'b0;
      cache_addr[i] = '0; cache_wdata[i] = '0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // Reset in the middle of a demand fetch abandons it.
    cache_addr[0] = 32'h300; cache_read[0] = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("pre_rst_mem_read", 256'(mem_read[0]), 256'(1));
    chk("pre_rst_miss", 256'(miss0), 256'(1));
    rst_n = 1'b0; cache_read[0] = 1'b0;
    #1;
    chk("rst_mem_read", 256'(mem_read[0]), 256'(0));
    chk("rst_mem_addr", 256'(mem_addr[0]), 256'(0));
    chk("rst_cache_resp", 256'(cache_resp[0]), 256'(0));
    chk("rst_cache_rdata", cache_rdata[0], 256'(0));
    chk("rst_miss", 256'(miss0), 256'(0));
    chk("rst_hit", 256'(hit0), 256'(0));
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // Demand miss, then next-line prefetch.
    push_mem(0, 1'b0, 32'h100, '0);
    push_mem(0, 1'b0, 32'h120, '0);
    do_req(0, 1'b0, 32'h100, line_data(32'h100), lat);
    idle(10);
    chk("miss_after_100", 256'(miss0), 256'(1));
    chk("hit_after_100", 256'(hit0), 256'(0));

    // Buffer hit answered one cycle after the request; chains a prefetch of 0x140.
    push_mem(0, 1'b0, 32'h140, '0);
    do_req(0, 1'b0, 32'h120, line_data(32'h120), lat);
    chk("hit_latency", 256'(lat), 256'(1));
    idle(10);
    chk("hit_after_120", 256'(hit0), 256'(1));

    // Write to the buffered line passes through and invalidates it.
    push_mem(0, 1'b1, 32'h140, {8{32'hDEAD_BEEF}});
    do_req(0, 1'b1, 32'h140, {8{32'hDEAD_BEEF}}, lat);
    push_mem(0, 1'b0, 32'h140, '0);
    push_mem(0, 1'b0, 32'h160, '0);
    do_req(0, 1'b0, 32'h140, line_data(32'h140), lat);
    idle(10);
    chk("miss_after_wr_inval", 256'(miss0), 256'(2));

    // Request arriving during the prefetch of its line waits, then hits.
    push_mem(0, 1'b0, 32'h180, '0);
    push_mem(0, 1'b0, 32'h1A0, '0);
    push_mem(0, 1'b0, 32'h1C0, '0);
    do_req(0, 1'b0, 32'h180, line_data(32'h180), lat);
    do_req(0, 1'b0, 32'h1A0, line_data(32'h1A0), lat);
    chk("held_during_pf", 256'(lat > 2), 256'(1));
    idle(10);
    chk("hit_after_held", 256'(hit0), 256'(2));
    chk("miss_after_held", 256'(miss0), 256'(3));

    // Top line: demand only, no prefetch past 0x07FFFFFF.
    push_mem(0, 1'b0, 32'hFFFF_FFE0, '0);
    do_req(0, 1'b0, 32'hFFFF_FFE0, line_data(32'hFFFF_FFE0), lat);
    idle(10);
    chk("miss_after_top", 256'(miss0), 256'(4));

    // Prefetch disabled: sequential reads all miss; 2-bit miss counter saturates at 3.
    push_mem(1, 1'b0, 32'h200, '0);
    do_req(1, 1'b0, 32'h200, line_data(32'h200), lat);
    push_mem(1, 1'b0, 32'h220, '0);
    do_req(1, 1'b0, 32'h220, line_data(32'h220), lat);
    idle(10);
    chk("nopf_miss2", 256'(miss1), 256'(2));
    push_mem(1, 1'b0, 32'h200, '0);
    do_req(1, 1'b0, 32'h200, line_data(32'h200), lat);
    push_mem(1, 1'b0, 32'h200, '0);
    do_req(1, 1'b0, 32'h200, line_data(32'h200), lat);
    idle(10);
    chk("nopf_miss_sat", 256'(miss1), 256'(3));
    chk("nopf_hit", 256'(hit1), 256'(0));

    idle(20);
    chk("q_mem0_drained", 256'(q_mem0.size()), 256'(0));
    chk("q_mem1_drained", 256'(q_mem1.size()), 256'(0));
    chk("q_cache0_drained", 256'(q_cache0.size()), 256'(0));
    chk("q_cache1_drained", 256'(q_cache1.size()), 256'(0));

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
